// File: rtl/timer_down.sv
// mm:ss countdown timer with IDLE/RUN/PAUSE/ALARM control.
// The digits, FSM state and status flags all update together on the clock edge.
module timer_down #(
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en1hz,
    input  logic       clr,
    input  logic       start_stop,
    input  logic       minup,
    input  logic       secup,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_ALARM = 2'd3} state_t;

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SEC - 1);

    state_t     r_state, w_state_next;
    logic [2:0] r_mt, r_st, w_mt_next, w_st_next, w_mt_inc, w_st_inc, w_mt_dec, w_st_dec;
    logic [3:0] r_mo, r_so, w_mo_next, w_so_next, w_mo_inc, w_so_inc, w_mo_dec, w_so_dec;
    logic [7:0] r_cnt, w_cnt_next;
    logic       r_running, r_alarm, w_running_next, w_alarm_next;
    logic       w_zero, w_one;

    assign w_zero = (r_mt == 3'd0) && (r_mo == 4'd0) && (r_st == 3'd0) && (r_so == 4'd0);
    assign w_one  = (r_mt == 3'd0) && (r_mo == 4'd0) && (r_st == 3'd0) && (r_so == 4'd1);

    // BCD +1 with 59 -> 00 wrap for each field independently.
    always_comb begin
        w_so_inc = (r_so == 4'd9) ? 4'd0 : r_so + 4'd1;
        w_st_inc = (r_so != 4'd9) ? r_st : ((r_st == 3'd5) ? 3'd0 : r_st + 3'd1);
        w_mo_inc = (r_mo == 4'd9) ? 4'd0 : r_mo + 4'd1;
        w_mt_inc = (r_mo != 4'd9) ? r_mt : ((r_mt == 3'd5) ? 3'd0 : r_mt + 3'd1);
    end

    // BCD -1 with borrow from seconds into minutes; never applied at 00:00.
    always_comb begin
        w_so_dec = r_so;
        w_st_dec = r_st;
        w_mo_dec = r_mo;
        w_mt_dec = r_mt;
        if (r_so != 4'd0) begin
            w_so_dec = r_so - 4'd1;
        end else if (r_st != 3'd0) begin
            w_st_dec = r_st - 3'd1;
            w_so_dec = 4'd9;
        end else begin
            w_st_dec = 3'd5;
            w_so_dec = 4'd9;
            if (r_mo != 4'd0) begin
                w_mo_dec = r_mo - 4'd1;
            end else if (r_mt != 3'd0) begin
                w_mt_dec = r_mt - 3'd1;
                w_mo_dec = 4'd9;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mt      <= 3'd0;
            r_mo      <= 4'd0;
            r_st      <= 3'd0;
            r_so      <= 4'd0;
            r_cnt     <= 8'd0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mt      <= w_mt_next;
            r_mo      <= w_mo_next;
            r_st      <= w_st_next;
            r_so      <= w_so_next;
            r_cnt     <= w_cnt_next;
            r_running <= w_running_next;
            r_alarm   <= w_alarm_next;
        end
    end

    // Priority: clr > start_stop > en1hz > minup/secup.
    always_comb begin
        w_state_next = r_state;
        w_mt_next    = r_mt;
        w_mo_next    = r_mo;
        w_st_next    = r_st;
        w_so_next    = r_so;
        w_cnt_next   = r_cnt;
        if (clr) begin
            w_state_next = S_IDLE;
            w_mt_next    = 3'd0;
            w_mo_next    = 4'd0;
            w_st_next    = 3'd0;
            w_so_next    = 4'd0;
            w_cnt_next   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_stop && !w_zero) begin
                        w_state_next = S_RUN;
                    end else begin
                        if (secup) begin
                            w_st_next = w_st_inc;
                            w_so_next = w_so_inc;
                        end
                        if (minup) begin
                            w_mt_next = w_mt_inc;
                            w_mo_next = w_mo_inc;
                        end
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        w_state_next = S_PAUSE;
                    end else if (en1hz) begin
                        w_mt_next = w_mt_dec;
                        w_mo_next = w_mo_dec;
                        w_st_next = w_st_dec;
                        w_so_next = w_so_dec;
                        if (w_one) begin
                            w_state_next = S_ALARM;
                            w_cnt_next   = 8'd0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        w_state_next = S_RUN;
                    end
                end
                S_ALARM: begin
                    if (start_stop) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = 8'd0;
                    end else if (en1hz) begin
                        if (r_cnt == ALARM_LAST) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = 8'd0;
                        end else begin
                            w_cnt_next = r_cnt + 8'd1;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_running_next = (w_state_next == S_RUN);
        w_alarm_next   = (w_state_next == S_ALARM);
    end

    assign min_tens  = r_mt;
    assign min_ones  = r_mo;
    assign sec_tens  = r_st;
    assign sec_ones  = r_so;
    assign running   = r_running;
    assign alarm     = r_alarm;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_timer_down.sv
// Directed bench for timer_down: set, countdown/borrow, alarm timeout,
// pause/resume, input priority and asynchronous reset.
module tb_timer_down;
    logic       clk = 1'b0;
    logic       rst;
    logic       en1hz, clr, start_stop, minup, secup;
    logic [2:0] min_tens, sec_tens;
    logic [3:0] min_ones, sec_ones;
    logic       running, alarm;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_ALARM = 2'd3;

    timer_down #(.ALARM_SEC(3)) dut (
        .clk(clk), .rst(rst), .en1hz(en1hz), .clr(clr), .start_stop(start_stop),
        .minup(minup), .secup(secup),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .alarm(alarm), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        logic [13:0] exp;
        exp = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
        chk(tag, {2'b00, min_tens, min_ones, sec_tens, sec_ones}, {2'b00, exp});
    endtask

    // One-cycle pulse: inputs set at negedge, sampled at posedge, cleared at next negedge.
    task automatic step(input logic c, input logic s, input logic e, input logic mu, input logic su);
        clr = c; start_stop = s; en1hz = e; minup = mu; secup = su;
        @(negedge clk);
        clr = 0; start_stop = 0; en1hz = 0; minup = 0; secup = 0;
    endtask

    task automatic repeat_step(input int n, input logic e, input logic mu, input logic su);
        for (int i = 0; i < n; i++) step(0, 0, e, mu, su);
    endtask

    initial begin
        rst = 1; en1hz = 0; clr = 0; start_stop = 0; minup = 0; secup = 0;
        repeat (2) @(negedge clk);
        chk_time("reset_digits", 0, 0);
        chk("reset_running", 16'(running), 16'd0);
        chk("reset_alarm", 16'(alarm), 16'd0);
        chk("reset_state", 16'(dbg_state), 16'(ST_IDLE));
        rst = 0;
        @(negedge clk);

        // Setting and seconds wrap
        repeat_step(3, 0, 1, 0);
        repeat_step(12, 0, 0, 1);
        chk_time("set_0312", 3, 12);
        chk("set_running", 16'(running), 16'd0);
        repeat_step(60, 0, 0, 1);
        chk_time("sec_wrap_0312", 3, 12);
        step(0, 0, 1, 0, 0);
        chk_time("idle_en_ignored", 3, 12);
        step(0, 0, 0, 1, 1);
        chk_time("min_sec_same_cycle", 4, 13);
        step(1, 0, 0, 0, 0);
        repeat_step(59, 0, 1, 0);
        chk_time("min_59", 59, 0);
        step(0, 0, 0, 1, 0);
        chk_time("min_wrap", 0, 0);

        // Countdown with borrow
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        chk("start_running", 16'(running), 16'd1);
        step(0, 0, 1, 0, 0);
        chk_time("borrow_0059", 0, 59);
        chk("run_running", 16'(running), 16'd1);
        step(1, 0, 0, 0, 0);
        repeat_step(10, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_time("borrow_0959", 9, 59);

        // Terminal count and alarm timeout
        step(1, 0, 0, 0, 0);
        repeat_step(2, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_time("term_0001", 0, 1);
        chk("term_alarm_pre", 16'(alarm), 16'd0);
        step(0, 0, 1, 0, 0);
        chk_time("term_0000", 0, 0);
        chk("term_alarm", 16'(alarm), 16'd1);
        chk("term_running", 16'(running), 16'd0);
        chk("term_state", 16'(dbg_state), 16'(ST_ALARM));
        repeat_step(2, 1, 0, 0);
        chk("alarm_hold_2", 16'(alarm), 16'd1);
        step(0, 0, 0, 1, 1);
        chk_time("alarm_set_ignored", 0, 0);
        step(0, 0, 1, 0, 0);
        chk("alarm_timeout", 16'(alarm), 16'd0);
        chk("alarm_timeout_state", 16'(dbg_state), 16'(ST_IDLE));

        // Pause/resume
        step(1, 0, 0, 0, 0);
        repeat_step(30, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk_time("pause_0030", 0, 30);
        chk("pause_state", 16'(dbg_state), 16'(ST_PAUSE));
        chk("pause_running", 16'(running), 16'd0);
        repeat_step(5, 1, 1, 1);
        chk_time("pause_frozen", 0, 30);
        step(0, 1, 0, 0, 0);
        chk("resume_running", 16'(running), 16'd1);
        chk_time("resume_no_tick", 0, 30);
        step(0, 0, 1, 0, 0);
        chk_time("resume_0029", 0, 29);

        // Priority and ignores
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("start_at_zero", 16'(dbg_state), 16'(ST_IDLE));
        repeat_step(5, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk_time("clr_priority", 0, 0);
        chk("clr_priority_state", 16'(dbg_state), 16'(ST_IDLE));
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("ack_alarm_on", 16'(alarm), 16'd1);
        step(0, 1, 0, 0, 0);
        chk("ack_alarm_off", 16'(alarm), 16'd0);
        chk("ack_state", 16'(dbg_state), 16'(ST_IDLE));
        step(0, 0, 1, 0, 0);
        chk("ack_no_restart", 16'(dbg_state), 16'(ST_IDLE));
        chk_time("ack_digits", 0, 0);

        // Asynchronous reset mid-run
        repeat_step(5, 0, 1, 0);
        repeat_step(43, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk_time("pre_rst_0543", 5, 43);
        chk("pre_rst_running", 16'(running), 16'd1);
        #2 rst = 1;
        #1;
        chk_time("async_rst_digits", 0, 0);
        chk("async_rst_running", 16'(running), 16'd0);
        chk("async_rst_state", 16'(dbg_state), 16'(ST_IDLE));
        @(negedge clk);
        rst = 0;
        step(0, 0, 1, 0, 0);
        chk_time("post_rst_no_tick", 0, 0);
        chk("post_rst_state", 16'(dbg_state), 16'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/timer_down.md
Name: timer_down

Overview:
- Countdown timer (mm:ss) that counts toward 00:00, the reverse of the up-counting clock.
- Sits between the button-pulse block and the 1 Hz enable generator on the input side, and the four 7-segment decoders on the output side.
- User sets minutes and seconds, then starts, pauses or clears the count.
- On reaching 00:00 it raises an alarm flag for a bounded number of seconds.

Parameters:
- ALARM_SEC, 10: number of en1hz ticks the alarm stays asserted before auto-return to IDLE; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en1hz  in  1  one-cycle pulse, once per second
- clr  in  1  one-cycle pulse: clear to 00:00, go IDLE
- start_stop  in  1  one-cycle pulse: start / pause / resume / acknowledge alarm
- minup  in  1  one-cycle pulse: increment minutes (IDLE only)
- secup  in  1  one-cycle pulse: increment seconds (IDLE only)
- min_tens  out  3  minutes tens digit, 0..5
- min_ones  out  4  minutes ones digit, 0..9
- sec_tens  out  3  seconds tens digit, 0..5
- sec_ones  out  4  seconds ones digit, 0..9
- running  out  1  high while in RUN
- alarm  out  1  high while in ALARM

Behaviour:
- All outputs registered. Reset (async, rst=1) forces:
  - all digits 0, state IDLE, running=0, alarm=0, alarm tick counter 0.
- States: IDLE, RUN, PAUSE, ALARM. Every transition and digit update takes effect on the clk edge where the pulse is sampled high.
- Input priority within a cycle: clr > start_stop > en1hz > minup/secup.
- clr, in any state: digits to 00:00, state to IDLE, alarm=0 on the next edge.
- IDLE:
  - secup: seconds +1, 59 wraps to 00, no carry into minutes.
  - minup: minutes +1, 59 wraps to 00.
  - minup and secup in the same cycle: both applied.
  - start_stop with value != 00:00: go to RUN. With value 00:00: ignored, stay IDLE.
  - en1hz ignored.
- RUN:
  - en1hz: decrement by 1 s in BCD.
    - sec_ones 0 becomes 9 and borrows from sec_tens.
    - sec_tens 0 with sec_ones 0 becomes 59 and borrows from minutes; minutes follow the same rule.
  - Tick when value is 00:01: digits become 00:00, state becomes ALARM, alarm=1 on that same edge.
  - start_stop: go to PAUSE. An en1hz in the same cycle is discarded (no decrement).
  - minup/secup ignored.
- PAUSE:
  - Digits frozen; en1hz, minup and secup ignored.
  - start_stop: go to RUN. Counting resumes at the next en1hz.
- ALARM:
  - Digits held at 00:00; alarm=1.
  - Counter increments on each en1hz. When it reaches ALARM_SEC: go to IDLE, alarm=0, counter cleared.
  - start_stop or clr: immediate return to IDLE, alarm=0, counter cleared. This start_stop does not restart the timer.
  - minup/secup ignored.
- running = (state==RUN); alarm = (state==ALARM). Both change on the same edge as the state.
- Digit values outside the ranges above are never produced. Width truncation is not permitted.
- Reset asserted mid-RUN or mid-ALARM: immediate return to reset values. No tick is pending after release.

Test Plan:
- Reset then set: 3×minup, 12×secup in IDLE → digits 03:12, running=0. Then 60×secup → 03:12 again (wrap, minutes unchanged).
- Countdown with borrow: set 01:00, start_stop, one en1hz → 00:59, running=1. Set 10:00, one tick → 09:59.
- Terminal count: set 00:02, start, two en1hz → 00:00, alarm=1 on second tick edge, running=0. ALARM_SEC=3, three more en1hz → alarm=0, state IDLE.
- Pause/resume: from 00:30 RUN, start_stop coincident with en1hz → PAUSE at 00:30. Five en1hz ignored, still 00:30. start_stop then en1hz → 00:29.
- Priority and ignores: start_stop at 00:00 in IDLE → stays IDLE. In RUN assert clr+start_stop+en1hz together → 00:00 IDLE. start_stop during ALARM → alarm=0 next edge, timer not restarted.
- Async reset: assert rst between clk edges during RUN at 05:43 → outputs zero immediately, before the next clk edge.
